// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and default timing constants for the alarm trigger.
package alarm_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RING    = 2'd1;
  localparam logic [1:0] ST_SNOOZE  = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;
  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    RING    = ST_RING,
    SNOOZE  = ST_SNOOZE,
    LOCKOUT = ST_LOCKOUT
  } state_t;
  localparam int DEF_TICKS_PER_SEC  = 1000;
  localparam int DEF_RING_SECONDS   = 60;
  localparam int DEF_SNOOZE_SECONDS = 300;
  localparam int DEF_MAX_SNOOZE     = 3;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: rising-edge detector for a debounced level button, one history register.
module btn_edge (
  input  logic clk1khz,
  input  logic rst,
  input  logic in,
  output logic rise
);
  logic r_prev;
  always_ff @(posedge clk1khz or posedge rst)
    if (rst) r_prev <= 1'b0;
    else     r_prev <= in;
  assign rise = in & ~r_prev;
endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger: ring/snooze/lockout sequencer driven by an hour:minute alarm match.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int TICKS_PER_SEC  = DEF_TICKS_PER_SEC,
  parameter int RING_SECONDS   = DEF_RING_SECONDS,
  parameter int SNOOZE_SECONDS = DEF_SNOOZE_SECONDS,
  parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE
) (
  input  logic       clk1khz,
  input  logic       rst,
  input  logic       enable,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [4:0] alm_hour,
  input  logic [5:0] alm_min,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       on,
  output logic       snoozing
);
  localparam logic [31:0] RING_LAST = 32'(RING_SECONDS * TICKS_PER_SEC - 1);
  localparam logic [31:0] SNZ_LAST  = 32'(SNOOZE_SECONDS * TICKS_PER_SEC - 1);
  localparam logic [7:0]  SNZ_MAX   = 8'(MAX_SNOOZE);
  state_t      r_state;
  logic [31:0] r_cnt;
  logic [7:0]  r_snz;
  logic        w_match, w_stop, w_snooze, w_snz_ok;
  assign w_match  = enable && cur_hour == alm_hour && cur_min == alm_min;
  assign w_snz_ok = w_snooze && r_snz < SNZ_MAX;
  btn_edge u_stop (.clk1khz(clk1khz), .rst(rst), .in(stop_btn), .rise(w_stop));
  btn_edge u_snz  (.clk1khz(clk1khz), .rst(rst), .in(snooze_btn), .rise(w_snooze));
  // The duration counter restarts on every transition; each branch that moves state clears it.
  always_ff @(posedge clk1khz or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_snz   <= '0;
    end else if (!enable) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_snz   <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      case (r_state)
        IDLE:
          if (w_match) begin
            r_state <= RING;
            r_cnt   <= '0;
            r_snz   <= '0;
          end
        RING:
          if (w_stop) begin
            r_state <= LOCKOUT;
            r_cnt   <= '0;
          end else if (w_snz_ok) begin
            r_state <= SNOOZE;
            r_cnt   <= '0;
            r_snz   <= r_snz + 8'd1;
          end else if (r_cnt == RING_LAST) begin
            r_state <= LOCKOUT;
            r_cnt   <= '0;
          end
        SNOOZE:
          if (w_stop) begin
            r_state <= LOCKOUT;
            r_cnt   <= '0;
          end else if (r_cnt == SNZ_LAST) begin
            r_state <= RING;
            r_cnt   <= '0;
          end
        default:
          if (!w_match) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
      endcase
    end
  assign on       = r_state == RING;
  assign snoozing = r_state == SNOOZE;
endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger: directed checks of ring, snooze, stop, enable and reset behaviour.
module tb_alarm_trigger;
  logic       clk1khz = 1'b0;
  logic       rst, enable, stop_btn, snooze_btn, on, snoozing;
  logic [4:0] cur_hour, alm_hour;
  logic [5:0] cur_min, alm_min;
  int         checks = 0;
  int         failures = 0;
  int         n;
  always #5 clk1khz = ~clk1khz;
  alarm_trigger #(
    .TICKS_PER_SEC(10), .RING_SECONDS(3), .SNOOZE_SECONDS(2), .MAX_SNOOZE(2)
  ) dut (
    .clk1khz(clk1khz), .rst(rst), .enable(enable),
    .cur_hour(cur_hour), .cur_min(cur_min), .alm_hour(alm_hour), .alm_min(alm_min),
    .stop_btn(stop_btn), .snooze_btn(snooze_btn), .on(on), .snoozing(snoozing)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk1khz);
  endtask
  // Counts consecutive samples (starting now) with the selected output high.
  task automatic run_len(input bit sel, output int len);
    len = 0;
    while (((sel ? snoozing : on) === 1'b1) && len < 200) begin
      len++;
      @(negedge clk1khz);
    end
  endtask
  task automatic new_event();
    cur_min = 6'd31;
    tick(1);
    cur_min = 6'd30;
    tick(1);
  endtask
  initial begin
    rst = 1'b1; enable = 1'b1; stop_btn = 1'b0; snooze_btn = 1'b0;
    alm_hour = 5'd7; alm_min = 6'd30; cur_hour = 5'd7; cur_min = 6'd29;
    tick(2);
    chk("reset_on", on, 0);
    chk("reset_snoozing", snoozing, 0);
    rst = 1'b0;
    tick(2);
    chk("idle_no_match", on, 0);
    cur_min = 6'd30;
    tick(1);
    chk("ring_start", on, 1);
    run_len(0, n);
    chk("ring_len", n, 30);
    chk("lockout_snoozing", snoozing, 0);
    tick(5);
    chk("no_retrigger_same_min", on, 0);
    cur_min = 6'd31;
    tick(1);
    chk("idle_next_min", on, 0);
    cur_min = 6'd30;
    tick(1);
    chk("retrigger", on, 1);
    tick(4);
    snooze_btn = 1'b1;
    tick(1);
    chk("snooze_on_low", on, 0);
    chk("snooze_entered", snoozing, 1);
    snooze_btn = 1'b0;
    run_len(1, n);
    chk("snooze_len", n, 20);
    run_len(0, n);
    chk("ring_after_snooze_len", n, 30);
    new_event();
    chk("event3_ring", on, 1);
    snooze_btn = 1'b1;
    tick(1);
    chk("event3_snooze1", snoozing, 1);
    snooze_btn = 1'b0;
    tick(5);
    snooze_btn = 1'b1;
    run_len(1, n);
    chk("snooze_in_snooze_ignored", n, 15);
    snooze_btn = 1'b0;
    chk("event3_ring2", on, 1);
    tick(1);
    snooze_btn = 1'b1;
    tick(1);
    chk("event3_snooze2", snoozing, 1);
    snooze_btn = 1'b0;
    run_len(1, n);
    chk("event3_snooze2_len", n, 20);
    snooze_btn = 1'b1;
    run_len(0, n);
    chk("third_snooze_ignored_len", n, 30);
    chk("third_snooze_not_snoozing", snoozing, 0);
    snooze_btn = 1'b0;
    new_event();
    chk("event4_ring", on, 1);
    tick(2);
    stop_btn = 1'b1;
    snooze_btn = 1'b1;
    tick(1);
    chk("stop_and_snooze_on", on, 0);
    chk("stop_and_snooze_snoozing", snoozing, 0);
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    tick(3);
    chk("lockout_hold", on | snoozing, 0);
    new_event();
    snooze_btn = 1'b1;
    tick(1);
    chk("event5_snooze", snoozing, 1);
    snooze_btn = 1'b0;
    tick(3);
    stop_btn = 1'b1;
    tick(1);
    chk("stop_from_snooze", on | snoozing, 0);
    stop_btn = 1'b0;
    new_event();
    snooze_btn = 1'b1;
    tick(1);
    chk("event6_snooze", snoozing, 1);
    snooze_btn = 1'b0;
    tick(3);
    enable = 1'b0;
    tick(1);
    chk("disable_snoozing", snoozing, 0);
    chk("disable_on", on, 0);
    enable = 1'b1;
    tick(1);
    chk("reenable_retrigger", on, 1);
    run_len(0, n);
    chk("reenable_ring_len", n, 30);
    new_event();
    tick(9);
    chk("ring_cycle10", on, 1);
    #2 rst = 1'b1;
    #1 chk("async_reset_drop", on, 0);
    tick(2);
    chk("reset_hold", on | snoozing, 0);
    rst = 1'b0;
    tick(1);
    chk("ring_after_reset", on, 1);
    run_len(0, n);
    chk("ring_after_reset_len", n, 30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alarm_trigger.md
ALARM_TRIGGER -- requirements
Module: alarm_trigger

Interface
REQ-001 Parameter TICKS_PER_SEC, default 1000: clk1khz cycles per second.
REQ-002 Parameter RING_SECONDS, default 60: length of one ring period, in seconds.
REQ-003 Parameter SNOOZE_SECONDS, default 300: length of one snooze pause, in seconds.
REQ-004 Parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event.
REQ-005 clk1khz  in  1  sole clock, 1 kHz.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  alarm armed; level.
REQ-008 cur_hour  in  5  current hour, binary 0..23.
REQ-009 cur_min  in  6  current minute, binary 0..59.
REQ-010 alm_hour  in  5  alarm hour, binary 0..23.
REQ-011 alm_min  in  6  alarm minute, binary 0..59.
REQ-012 stop_btn  in  1  debounced stop button; level, active-high.
REQ-013 snooze_btn  in  1  debounced snooze button; level, active-high.
REQ-014 on  out  1  ring request driving the LED pattern generator downstream.
REQ-015 snoozing  out  1  high while in SNOOZE.

Function
REQ-016 match SHALL be enable AND cur_hour==alm_hour AND cur_min==alm_min, evaluated combinationally.
REQ-017 Button presses SHALL be rising edges, detected from one register stage per button: edge = current AND NOT previous.
REQ-018 FSM states SHALL be IDLE, RING, SNOOZE and LOCKOUT, held in a registered state vector.
REQ-019 IDLE->RING SHALL occur on the clock edge where match=1; the snooze count is cleared at the same edge.
REQ-020 The exit from RING SHALL be chosen by priority: stop edge -> LOCKOUT; else snooze edge with snooze count < MAX_SNOOZE -> SNOOZE (snooze count +1); else ring timer expiry -> LOCKOUT.
REQ-021 The ring timer SHALL expire after exactly RING_SECONDS*TICKS_PER_SEC cycles in RING.
REQ-022 From SNOOZE, a stop edge SHALL go to LOCKOUT; otherwise, after exactly SNOOZE_SECONDS*TICKS_PER_SEC cycles, the FSM SHALL return to RING with a fresh ring timer.
REQ-023 A snooze edge with snooze count == MAX_SNOOZE SHALL be ignored.
REQ-024 A snooze edge received in SNOOZE SHALL be ignored and SHALL NOT restart the timer.
REQ-025 LOCKOUT->IDLE SHALL occur only on the first cycle where match=0, so the same minute cannot retrigger.
REQ-026 enable=0 SHALL force IDLE on the next edge from any state, clearing the timer and the snooze count.
REQ-027 A simultaneous stop and snooze edge SHALL be treated as stop.
REQ-028 on SHALL equal (state==RING) and snoozing SHALL equal (state==SNOOZE); both are decoded from registered state with no combinational path from the inputs.
REQ-029 The single duration counter SHALL be 32 bits wide, reset to 0 on every state change, and incremented once per cycle otherwise; expiry is counter == N-1.
REQ-030 The snooze count SHALL saturate at MAX_SNOOZE and never wrap.
REQ-031 Alarm-time changes while in RING or SNOOZE SHALL NOT affect the current event; they take effect only through LOCKOUT/IDLE evaluation.

Reset
REQ-032 While rst=1, the block SHALL hold: state=IDLE, counter=0, snooze count=0, button history=0, on=0, snoozing=0.
REQ-033 Reset asserted mid-ring SHALL drop on within the same cycle, asynchronously.
REQ-034 After reset deassertion with match=1, RING SHALL be entered on the first clock edge, since IDLE has no lockout.

Structure
REQ-035 State encoding localparams and the default timing constants SHALL reside in the shared package alarm_pkg.
REQ-036 Edge detection SHALL be a sub-module btn_edge (clk1khz, rst, in, rise), instantiated twice.

Verification
Bench parameters: TICKS_PER_SEC=10, RING_SECONDS=3, SNOOZE_SECONDS=2, MAX_SNOOZE=2.
REQ-037 Set alm 07:30 and drive cur 07:30 with enable=1 -> on=1 one cycle later, for exactly 30 cycles, then LOCKOUT; no retrigger until cur_min changes to 07:31.
REQ-038 Press snooze at ring cycle 5 -> on=0 and snoozing=1 for exactly 20 cycles, then on=1 for 30 cycles.
REQ-039 Press snooze three times across rings -> the third press is ignored and the ring runs its full 30 cycles.
REQ-040 Press stop and snooze on the same cycle during RING -> LOCKOUT, on=0, snoozing=0.
REQ-041 Drop enable during SNOOZE -> IDLE the next cycle; re-enabling within the same minute retriggers RING.
REQ-042 Assert rst at ring cycle 10 -> on=0 immediately; after release with match=1, RING is re-entered on the first edge.
